dispense_timer: RTL and testbench

//  Parametrised mm:ss countdown timer with an integrated 4-phase stepper dispense sequencer.
//  - Counts down a loaded time, then drives the motor for a fixed number of steps.
//  - Pauses the motor while the jam sensor is asserted; faults if the jam persists.
//  - Supports pause/resume, one-shot or auto-reload, and time clamping.
//  - Sits between the setpoint/keypad logic and the 4-phase motor driver pins.

---
 rtl/dispense_timer.sv | 207 ++++++++++++++++++++
 tb/tb_dispense_timer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispense_timer.sv
// dispense_timer: mm:ss countdown timer driving a 4-phase stepper dispense sequence.
// A loaded setpoint counts down once per second tick. At 0:00 the motor is stepped a
// fixed number of times. A blocked path pauses the motor, and a jam that persists
// latches a fault. Every output is a flop, so each output is computed from the next state.
module dispense_timer #(
    parameter int MIN_W          = 6,
    parameter int TICKS_PER_SEC  = 50,
    parameter int STEP_DIV       = 4,
    parameter int DISPENSE_STEPS = 512,
    parameter int BLOCK_TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_time,
    input  logic [5:0]       set_sec,
    input  logic [MIN_W-1:0] set_min,
    input  logic             run_en,
    input  logic             auto_reload,
    input  logic             sensor,
    output logic [5:0]       count_sec,
    output logic [MIN_W-1:0] count_min,
    output logic [3:0]       motor_phase,
    output logic             dispensing,
    output logic             done_pulse,
    output logic             fault
);

    // Each counter is one bit wider than its limit needs, so no counter can reach its limit and wrap unnoticed.
    localparam int TICK_W = $clog2(TICKS_PER_SEC) + 1;
    localparam int DIV_W  = $clog2(STEP_DIV) + 1;
    localparam int STEP_W = $clog2(DISPENSE_STEPS) + 1;
    localparam int BLK_W  = $clog2(BLOCK_TIMEOUT) + 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(DISPENSE_STEPS);
    localparam logic [BLK_W-1:0]  BLK_LIMIT = BLK_W'(BLOCK_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SET      = 3'd1,
        S_COUNT    = 3'd2,
        S_DISPENSE = 3'd3,
        S_HOLD     = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    state_t             state, state_n;
    logic [TICK_W-1:0]  tick_cnt, tick_n;
    logic [DIV_W-1:0]   div_cnt, div_n;
    logic [STEP_W-1:0]  step_cnt, step_n;
    logic [BLK_W-1:0]   blk_cnt, blk_n;
    logic [1:0]         phase_idx, phase_n;
    logic [5:0]         sp_sec, sp_sec_n;
    logic [MIN_W-1:0]   sp_min, sp_min_n;
    logic [5:0]         sec_n;
    logic [MIN_W-1:0]   min_n;
    logic [3:0]         motor_n;
    logic               dispensing_n, done_n, fault_n;
    logic [5:0]         sec_clamped;
    logic               count_zero, dec_to_zero, sp_zero;

    assign sec_clamped = (set_sec > 6'd59) ? 6'd59 : set_sec;
    assign count_zero  = (count_sec == 6'd0) && (count_min == '0);
    assign dec_to_zero = (count_sec == 6'd1) && (count_min == '0);
    assign sp_zero     = (sp_sec == 6'd0) && (sp_min == '0);

    // Register every piece of state. The synchronous active-low reset clears all of it, including the latched setpoint.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tick_cnt    <= '0;
            div_cnt     <= '0;
            step_cnt    <= '0;
            blk_cnt     <= '0;
            phase_idx   <= '0;
            sp_sec      <= '0;
            sp_min      <= '0;
            count_sec   <= '0;
            count_min   <= '0;
            motor_phase <= '0;
            dispensing  <= 1'b0;
            done_pulse  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_n;
            tick_cnt    <= tick_n;
            div_cnt     <= div_n;
            step_cnt    <= step_n;
            blk_cnt     <= blk_n;
            phase_idx   <= phase_n;
            sp_sec      <= sp_sec_n;
            sp_min      <= sp_min_n;
            count_sec   <= sec_n;
            count_min   <= min_n;
            motor_phase <= motor_n;
            dispensing  <= dispensing_n;
            done_pulse  <= done_n;
            fault       <= fault_n;
        end
    end

    // Compute the next state and counters. set_time overrides every state. The outputs are then derived from the next state.
    always_comb begin
        state_n  = state;
        tick_n   = tick_cnt;
        div_n    = div_cnt;
        step_n   = step_cnt;
        blk_n    = blk_cnt;
        phase_n  = phase_idx;
        sp_sec_n = sp_sec;
        sp_min_n = sp_min;
        sec_n    = count_sec;
        min_n    = count_min;
        done_n   = 1'b0;

        if (set_time) begin
            state_n  = S_SET;
            sec_n    = sec_clamped;
            min_n    = set_min;
            sp_sec_n = sec_clamped;
            sp_min_n = set_min;
            tick_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (run_en && !count_zero) begin
                        state_n = S_COUNT;
                    end
                end
                S_SET: begin
                    state_n = S_IDLE;
                end
                S_COUNT: begin
                    if (run_en) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_n = '0;
                            if (count_sec != 6'd0) begin
                                sec_n = count_sec - 6'd1;
                            end else if (count_min != '0) begin
                                sec_n = 6'd59;
                                min_n = count_min - 1'b1;
                            end else begin
                                state_n = S_IDLE;
                            end
                            if (dec_to_zero) begin
                                state_n = S_DISPENSE;
                                step_n  = STEP_W'(1);
                                div_n   = '0;
                                phase_n = '0;
                                blk_n   = '0;
                            end
                        end else begin
                            tick_n = tick_cnt + 1'b1;
                        end
                    end
                end
                S_DISPENSE: begin
                    if (sensor) begin
                        state_n = S_HOLD;
                        blk_n   = '0;
                    end else if (div_cnt == DIV_LAST) begin
                        div_n = '0;
                        if (step_cnt == STEP_LAST) begin
                            done_n = 1'b1;
                            if (auto_reload && !sp_zero) begin
                                state_n = S_COUNT;
                                sec_n   = sp_sec;
                                min_n   = sp_min;
                                tick_n  = '0;
                            end else begin
                                state_n = S_IDLE;
                            end
                        end else begin
                            step_n  = step_cnt + 1'b1;
                            phase_n = phase_idx + 2'd1;
                        end
                    end else begin
                        div_n = div_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!sensor) begin
                        state_n = S_DISPENSE;
                        blk_n   = '0;
                    end else begin
                        blk_n = blk_cnt + 1'b1;
                        if (blk_n == BLK_LIMIT) begin
                            state_n = S_FAULT;
                        end
                    end
                end
                S_FAULT: begin
                    state_n = S_FAULT;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end

        motor_n      = (state_n == S_DISPENSE) ? (4'b0001 << phase_n) : 4'b0000;
        dispensing_n = (state_n == S_DISPENSE) || (state_n == S_HOLD);
        fault_n      = (state_n == S_FAULT);
    end

endmodule

// File: tb/tb_dispense_timer.sv
// tb_dispense_timer: directed scenarios for dispense_timer with small parameters.
// The parameters are TICKS_PER_SEC=4, STEP_DIV=2, DISPENSE_STEPS=8 and BLOCK_TIMEOUT=10.
// Every expected output vector below was worked out by hand, one cycle at a time.
module tb_dispense_timer;

    logic       clk = 1'b0;
    logic       rst_n, set_time, run_en, auto_reload, sensor;
    logic [5:0] set_sec, set_min;
    logic [5:0] count_sec, count_min;
    logic [3:0] motor_phase;
    logic       dispensing, done_pulse, fault;
    logic [18:0] obs;

    int compared   = 0;
    int mismatched = 0;

    dispense_timer #(
        .MIN_W(6), .TICKS_PER_SEC(4), .STEP_DIV(2), .DISPENSE_STEPS(8), .BLOCK_TIMEOUT(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .set_time(set_time), .set_sec(set_sec), .set_min(set_min),
        .run_en(run_en), .auto_reload(auto_reload), .sensor(sensor),
        .count_sec(count_sec), .count_min(count_min), .motor_phase(motor_phase),
        .dispensing(dispensing), .done_pulse(done_pulse), .fault(fault)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // The observed vector is {min, sec, phase, dispensing, done_pulse, fault}.
    assign obs = {count_min, count_sec, motor_phase, dispensing, done_pulse, fault};

    // A global time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n rising edges and land 1 unit after the last one, away from the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; set_time = 1'b0; set_sec = 6'd0; set_min = 6'd0;
        run_en = 1'b0; auto_reload = 1'b0; sensor = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Load a setpoint and enable counting. The bench returns just after the IDLE->COUNT edge, where the tick count is 0.
    task automatic load_and_run(input logic [5:0] s, input logic [5:0] m);
        set_time = 1'b1; set_sec = s; set_min = m;
        step(1);
        set_time = 1'b0; run_en = 1'b1;
        step(2);
    endtask

    task automatic test_reset;
        logic [18:0] exp;
        rst_n = 1'b0; set_time = 1'b0; set_sec = 6'd9; set_min = 6'd3;
        run_en = 1'b1; auto_reload = 1'b1; sensor = 1'b1;
        step(1);
        exp = 19'd0;
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, exp); end
        rst_n = 1'b1; run_en = 1'b0; sensor = 1'b0; auto_reload = 1'b0;
        step(3);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL reset_idle_hold: got %h expected %h", obs, exp); end
    endtask

    task automatic test_countdown;
        logic [18:0] exp;
        logic [3:0]  ph;
        do_reset();
        set_time = 1'b1; set_sec = 6'd2; set_min = 6'd0;
        step(1);
        exp = {6'd0, 6'd2, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_load: got %h expected %h", obs, exp); end
        set_time = 1'b0; run_en = 1'b1;
        step(2);
        step(3);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_no_early_borrow: got %h expected %h", obs, exp); end
        step(1);
        exp = {6'd0, 6'd1, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_sec1: got %h expected %h", obs, exp); end
        step(3);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_sec1_hold: got %h expected %h", obs, exp); end
        step(1);
        for (int s = 0; s < 8; s++) begin
            ph = 4'b0001 << (s % 4);
            for (int h = 0; h < 2; h++) begin
                exp = {6'd0, 6'd0, ph, 3'b100};
                compared++;
                if (obs !== exp) begin
                    mismatched++;
                    $display("[TB] FAIL cd_phase_step%0d_cyc%0d: got %h expected %h", s, h, obs, exp);
                end
                step(1);
            end
        end
        exp = {6'd0, 6'd0, 4'b0000, 3'b010};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_done_pulse: got %h expected %h", obs, exp); end
        step(1);
        exp = 19'd0;
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_done_single: got %h expected %h", obs, exp); end
        step(10);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL cd_zero_stays_idle: got %h expected %h", obs, exp); end
    endtask

    task automatic test_clamp_pause;
        logic [18:0] exp;
        do_reset();
        set_time = 1'b1; set_sec = 6'd63; set_min = 6'd0;
        step(1);
        exp = {6'd0, 6'd59, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL clamp_63: got %h expected %h", obs, exp); end
        set_sec = 6'd0; set_min = 6'd1;
        step(1);
        exp = {6'd1, 6'd0, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL load_1m00: got %h expected %h", obs, exp); end
        set_time = 1'b0; run_en = 1'b1;
        step(2);
        step(3);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL borrow_not_early: got %h expected %h", obs, exp); end
        step(1);
        exp = {6'd0, 6'd59, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL borrow_0m59: got %h expected %h", obs, exp); end
        step(2);
        run_en = 1'b0;
        step(6);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL pause_frozen: got %h expected %h", obs, exp); end
        run_en = 1'b1;
        step(1);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL pause_tick_kept: got %h expected %h", obs, exp); end
        step(1);
        exp = {6'd0, 6'd58, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL resume_0m58: got %h expected %h", obs, exp); end
    endtask

    task automatic test_jam_resume;
        logic [18:0] exp;
        logic [3:0]  prev;
        int          new_steps;
        bit          seen_done;
        do_reset();
        load_and_run(6'd1, 6'd0);
        step(4);
        exp = {6'd0, 6'd0, 4'b0001, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL jam_first_step: got %h expected %h", obs, exp); end
        step(5);
        exp = {6'd0, 6'd0, 4'b0100, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL jam_pre_hold: got %h expected %h", obs, exp); end
        sensor = 1'b1;
        step(1);
        exp = {6'd0, 6'd0, 4'b0000, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL jam_hold_entry: got %h expected %h", obs, exp); end
        step(2);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL jam_hold_stay: got %h expected %h", obs, exp); end
        sensor = 1'b0;
        step(1);
        exp = {6'd0, 6'd0, 4'b0100, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL jam_resume_phase: got %h expected %h", obs, exp); end
        prev = 4'b0100; new_steps = 0; seen_done = 1'b0;
        for (int i = 0; i < 40 && !seen_done; i++) begin
            step(1);
            if (done_pulse) seen_done = 1'b1;
            else if (motor_phase != 4'b0000 && motor_phase != prev) begin
                new_steps++;
                prev = motor_phase;
            end
        end
        compared++;
        if (seen_done !== 1'b1) begin mismatched++; $display("[TB] FAIL jam_done_seen: got %0d expected 1", seen_done); end
        compared++;
        if (new_steps != 5) begin mismatched++; $display("[TB] FAIL jam_total_steps: got %0d expected 8", new_steps + 3); end
        compared++;
        if (prev !== 4'b1000) begin mismatched++; $display("[TB] FAIL jam_last_phase: got %b expected 1000", prev); end
    endtask

    task automatic test_fault;
        logic [18:0] exp;
        do_reset();
        load_and_run(6'd1, 6'd0);
        step(4);
        sensor = 1'b1;
        step(1);
        exp = {6'd0, 6'd0, 4'b0000, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL fault_hold_entry: got %h expected %h", obs, exp); end
        step(9);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL fault_not_early: got %h expected %h", obs, exp); end
        step(1);
        exp = {6'd0, 6'd0, 4'b0000, 3'b001};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL fault_set: got %h expected %h", obs, exp); end
        sensor = 1'b0;
        step(3);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL fault_sticky: got %h expected %h", obs, exp); end
        run_en = 1'b0; set_time = 1'b1; set_sec = 6'd5; set_min = 6'd0;
        step(1);
        exp = {6'd0, 6'd5, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL fault_cleared_set: got %h expected %h", obs, exp); end
        set_time = 1'b0;
        step(2);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL fault_after_set: got %h expected %h", obs, exp); end
    endtask

    task automatic test_auto_reload;
        logic [18:0] exp;
        do_reset();
        auto_reload = 1'b1;
        load_and_run(6'd1, 6'd0);
        step(4);
        exp = {6'd0, 6'd0, 4'b0001, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL ar_first_dispense: got %h expected %h", obs, exp); end
        step(15);
        exp = {6'd0, 6'd0, 4'b1000, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL ar_last_step: got %h expected %h", obs, exp); end
        step(1);
        exp = {6'd0, 6'd1, 4'b0000, 3'b010};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL ar_reload_done: got %h expected %h", obs, exp); end
        step(3);
        exp = {6'd0, 6'd1, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL ar_recount: got %h expected %h", obs, exp); end
        step(1);
        exp = {6'd0, 6'd0, 4'b0001, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL ar_second_dispense: got %h expected %h", obs, exp); end
        auto_reload = 1'b0;
    endtask

    task automatic test_reset_abort;
        logic [18:0] exp;
        do_reset();
        load_and_run(6'd1, 6'd0);
        step(6);
        exp = {6'd0, 6'd0, 4'b0010, 3'b100};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL abort_pre_reset: got %h expected %h", obs, exp); end
        rst_n = 1'b0;
        step(1);
        exp = 19'd0;
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL abort_reset_clear: got %h expected %h", obs, exp); end
        rst_n = 1'b1;
        step(3);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL abort_reset_idle: got %h expected %h", obs, exp); end
        load_and_run(6'd3, 6'd0);
        step(5);
        exp = {6'd0, 6'd2, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL midcount_sec2: got %h expected %h", obs, exp); end
        set_time = 1'b1; set_sec = 6'd3;
        step(1);
        exp = {6'd0, 6'd3, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL midcount_set: got %h expected %h", obs, exp); end
        set_time = 1'b0; run_en = 1'b0;
        step(20);
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL midcount_no_dispense: got %h expected %h", obs, exp); end
        load_and_run(6'd1, 6'd0);
        step(5);
        set_time = 1'b1; set_sec = 6'd2;
        step(1);
        exp = {6'd0, 6'd2, 4'b0000, 3'b000};
        compared++;
        if (obs !== exp) begin mismatched++; $display("[TB] FAIL dispense_abort: got %h expected %h", obs, exp); end
        set_time = 1'b0; run_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            compared++;
            if (obs !== exp) begin
                mismatched++;
                $display("[TB] FAIL abort_no_done_cyc%0d: got %h expected %h", i, obs, exp);
            end
        end
    endtask

    // Run the scenarios in order, then print the one summary line.
    initial begin
        do_reset();
        test_reset();
        test_countdown();
        test_clamp_pause();
        test_jam_resume();
        test_fault();
        test_auto_reload();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
